// File: rtl/cpu_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_seq_if
//  Description : Control bundle between the cpu_seq sequencer and the
//                datapath/memory side. The master drives the strobes;
//                the slave supplies the decoded instruction fields and
//                the memory handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
interface cpu_seq_if;
  // Decoded instruction fields and memory handshake (datapath -> sequencer)
  logic mem_ready;
  logic is_mem;
  logic is_load;
  logic is_branch;
  logic set_flags;
  logic halt;
  logic cond_pass;

  // Control strobes (sequencer -> datapath)
  logic fetch_req;
  logic ir_we;
  logic pc_we;
  logic pc_sel_branch;
  logic cpsr_we;
  logic reg_we;
  logic mem_req;
  logic mem_we;
  logic retire;

  modport master (
    input  mem_ready, is_mem, is_load, is_branch, set_flags, halt, cond_pass,
    output fetch_req, ir_we, pc_we, pc_sel_branch, cpsr_we, reg_we,
           mem_req, mem_we, retire
  );

  modport slave (
    output mem_ready, is_mem, is_load, is_branch, set_flags, halt, cond_pass,
    input  fetch_req, ir_we, pc_we, pc_sel_branch, cpsr_we, reg_we,
           mem_req, mem_we, retire
  );
endinterface
`default_nettype wire

// File: rtl/cpu_seq.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_seq
//  Description : Multi-cycle instruction sequencer. Walks each instruction
//                through FETCH / DECODE / EXEC / MEM / WB / BRANCH, emits
//                the datapath strobes and counts retired instructions.
//                HALT is absorbing until reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module cpu_seq #(
  parameter int CNT_W = 16
) (
  input  wire logic             clk,
  input  wire logic             nreset,
  cpu_seq_if.master             bus,
  output logic [2:0]            state,
  output logic                  halted,
  output logic [CNT_W-1:0]      instr_count
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_BRANCH = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd6;

  logic [2:0] cur_state;
  logic [2:0] next_state;

  // Instruction fields captured in DECODE and used through EXEC/MEM
  logic lat_is_mem;
  logic lat_is_load;
  logic lat_is_branch;
  logic lat_set_flags;

  // Ungated strobes; every one is forced low while reset is asserted
  logic fetch_req_c;
  logic ir_we_c;
  logic pc_we_c;
  logic pc_sel_c;
  logic cpsr_we_c;
  logic reg_we_c;
  logic mem_req_c;
  logic mem_we_c;
  logic retire_c;

  // State register; reset aborts any state, including a pending MEM wait
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      cur_state <= S_FETCH;
    end else begin
      cur_state <= next_state;
    end
  end

  // Capture decoded fields during the single DECODE cycle
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      lat_is_mem    <= 1'b0;
      lat_is_load   <= 1'b0;
      lat_is_branch <= 1'b0;
      lat_set_flags <= 1'b0;
    end else if (cur_state == S_DECODE) begin
      lat_is_mem    <= bus.is_mem;
      lat_is_load   <= bus.is_load;
      lat_is_branch <= bus.is_branch;
      lat_set_flags <= bus.set_flags;
    end
  end

  // Next-state logic; mem_ready only matters in FETCH and MEM
  always_comb begin
    next_state = cur_state;
    case (cur_state)
      S_FETCH:  if (bus.mem_ready) next_state = S_DECODE;
      S_DECODE: next_state = bus.halt ? S_HALT : S_EXEC;
      S_EXEC: begin
        if (!bus.cond_pass)   next_state = S_FETCH;
        else if (lat_is_branch) next_state = S_BRANCH;
        else if (lat_is_mem)    next_state = S_MEM;
        else                    next_state = S_WB;
      end
      S_MEM: begin
        if (bus.mem_ready) next_state = lat_is_load ? S_WB : S_FETCH;
      end
      S_WB:     next_state = S_FETCH;
      S_BRANCH: next_state = S_FETCH;
      S_HALT:   next_state = S_HALT;
      default:  next_state = S_FETCH;  // illegal code 7 recovers to FETCH
    endcase
  end

  // Output decode; retire strobes are Mealy on the leaving transition
  always_comb begin
    fetch_req_c = 1'b0;
    ir_we_c     = 1'b0;
    pc_we_c     = 1'b0;
    pc_sel_c    = 1'b0;
    cpsr_we_c   = 1'b0;
    reg_we_c    = 1'b0;
    mem_req_c   = 1'b0;
    mem_we_c    = 1'b0;
    retire_c    = 1'b0;
    case (cur_state)
      S_FETCH: begin
        fetch_req_c = 1'b1;
        ir_we_c     = bus.mem_ready;
      end
      S_EXEC: begin
        if (!bus.cond_pass) begin
          pc_we_c  = 1'b1;
          retire_c = 1'b1;
        end else begin
          cpsr_we_c = lat_set_flags;
        end
      end
      S_MEM: begin
        mem_req_c = 1'b1;
        mem_we_c  = ~lat_is_load;
        if (bus.mem_ready && !lat_is_load) begin
          pc_we_c  = 1'b1;
          retire_c = 1'b1;
        end
      end
      S_WB: begin
        reg_we_c = 1'b1;
        pc_we_c  = 1'b1;
        retire_c = 1'b1;
      end
      S_BRANCH: begin
        pc_we_c  = 1'b1;
        pc_sel_c = 1'b1;
        retire_c = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.fetch_req     = fetch_req_c & nreset;
  assign bus.ir_we         = ir_we_c     & nreset;
  assign bus.pc_we         = pc_we_c     & nreset;
  assign bus.pc_sel_branch = pc_sel_c    & nreset;
  assign bus.cpsr_we       = cpsr_we_c   & nreset;
  assign bus.reg_we        = reg_we_c    & nreset;
  assign bus.mem_req       = mem_req_c   & nreset;
  assign bus.mem_we        = mem_we_c    & nreset;
  assign bus.retire        = retire_c    & nreset;

  assign state  = cur_state;
  assign halted = (cur_state == S_HALT);

  // Retired-instruction counter; wraps naturally at 2^CNT_W
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      instr_count <= '0;
    end else if (retire_c) begin
      instr_count <= instr_count + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: doc/cpu_seq.md
CPU_SEQ -- requirements
Module: cpu_seq

Interface
REQ-001 Parameter CNT_W, default 16, sets the width of the retired-instruction counter.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 nreset  input  1  asynchronous, active-low reset.
REQ-004 mem_ready  input  1  memory handshake; the addressed access completes in this cycle.
REQ-005 is_mem  input  1  decoded instruction is a load or store; sampled in DECODE.
REQ-006 is_load  input  1  memory instruction is a load; sampled in DECODE.
REQ-007 is_branch  input  1  decoded instruction is a branch; sampled in DECODE.
REQ-008 set_flags  input  1  instruction updates CPSR; sampled in DECODE.
REQ-009 halt  input  1  halt request; sampled in DECODE.
REQ-010 cond_pass  input  1  condition check result; sampled live in EXEC.
REQ-011 fetch_req  output  1  instruction memory read strobe.
REQ-012 ir_we  output  1  latch the instruction register.
REQ-013 pc_we  output  1  PC update strobe.
REQ-014 pc_sel_branch  output  1  PC source: 1 selects the branch target, 0 selects PC+4.
REQ-015 cpsr_we  output  1  CPSR flag write enable.
REQ-016 reg_we  output  1  register file write enable.
REQ-017 mem_req  output  1  data memory access request.
REQ-018 mem_we  output  1  data memory write; valid only when mem_req is 1.
REQ-019 retire  output  1  one-cycle pulse per completed instruction.
REQ-020 state  output  3  current FSM state code.
REQ-021 halted  output  1  FSM is in HALT.
REQ-022 instr_count  output  CNT_W  retired-instruction count.

Function
REQ-023 The FSM SHALL use these state codes: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, BRANCH=5, HALT=6; code 7 is illegal and SHALL go to FETCH on the next edge.
REQ-024 FETCH: fetch_req=1. When mem_ready=1: ir_we=1 and next state is DECODE. When mem_ready=0: hold FETCH (unbounded wait).
REQ-025 DECODE: latch is_mem, is_load, is_branch and set_flags. Next state is HALT if halt=1, otherwise EXEC. Always exactly one cycle.
REQ-026 EXEC with cond_pass=0: retire the instruction (REQ-030) and go to FETCH; no cpsr_we, reg_we or mem_req.
REQ-027 EXEC with cond_pass=1: cpsr_we equals the latched set_flags for this one cycle.
- Next state is BRANCH if is_branch=1.
- Otherwise next state is MEM if is_mem=1.
- Otherwise next state is WB.
REQ-028 MEM: mem_req=1 and mem_we=~latched is_load, held until mem_ready=1.
- On completion of a load, next state is WB.
- On completion of a store, retire and go to FETCH.
REQ-029 WB: reg_we=1, retire, go to FETCH. BRANCH: pc_we=1 and pc_sel_branch=1, retire, go to FETCH.
REQ-030 "Retire" means pc_we=1 and retire=1 in the same cycle, with pc_sel_branch=1 only when retiring from BRANCH; these outputs are combinational (Mealy) on the transition.
REQ-031 instr_count SHALL increment by 1 on each edge where retire=1, and wrap from 2^CNT_W-1 to 0.
REQ-032 HALT is absorbing: all strobes are 0, halted=1, instr_count is frozen, and the only exit is reset. A halted instruction is not retired.
REQ-033 Latency: an ALU instruction takes 4 cycles (FETCH, DECODE, EXEC, WB) with mem_ready=1 in FETCH; a load takes 5 cycles plus memory wait cycles.
REQ-034 At most one of fetch_req and mem_req SHALL be 1 in any cycle.
REQ-035 mem_ready SHALL be ignored outside FETCH and MEM.

Reset
REQ-036 While nreset=0:
- state=FETCH and instr_count=0;
- every strobe output is 0, and fetch_req is gated with nreset;
- halted=0.
REQ-037 Assertion of nreset SHALL abort any state immediately, including a pending MEM wait, with no retire. The first fetch_req=1 appears in the first cycle after deassertion.

Verification
REQ-038 ALU instruction, cond_pass=1, mem_ready=1: state 0,1,2,4,0; reg_we and retire each high exactly once, in cycle 4; instr_count 0 to 1.
REQ-039 Load with mem_ready low for 3 MEM cycles: mem_req high for 4 cycles with mem_we=0, then WB; instr_count increments once.
REQ-040 Branch, cond_pass=1: BRANCH cycle has pc_we=1 and pc_sel_branch=1; same branch with cond_pass=0 returns from EXEC to FETCH with pc_sel_branch=0.
REQ-041 halt=1 in DECODE: state=6 and halted=1 indefinitely; instr_count unchanged after 100 cycles; nreset pulse returns to state 0 with count 0.
REQ-042 CNT_W=4, 16 back-to-back ALU instructions: instr_count 15 wraps to 0.
REQ-043 nreset asserted mid-MEM with mem_req=1: mem_req drops at once with no retire; after release, state=0 and fetch_req=1.
